// File: rtl/rvv_vd_collector.sv
// ---------------------------------------------------------------------------
// rvv_vd_collector
//
// Collects per-lane element results from the multi-lane vector ALU wrapper
// into one VLEN-bit destination buffer with per-byte enables. When the ALU
// signals its last beat (alu_done), the assembled register is offered to the
// vector register file on a valid/ready write-back port.
//
// Parameters
//   VLEN      vector register width in bits (multiple of 64)
//   NB_LANES  log2 of the lane count (0..3 -> 1..8 lanes)
//
// Ports
//   clk         clock
//   resetn      synchronous active-low reset
//   run         ALU stage running; rising edge starts a collection
//   vsew        element width code, SEW = 8 << vsew; codes above 3 are ignored
//   vd_addr_in  destination vector register number, latched at start
//   lane_vd     per-lane results, lane k = bits [64k+63:64k], low SEW bits used
//   lane_idx    per-lane element index, lane k = bits [10k+9:10k]
//   lane_valid  per-lane result valid
//   alu_done    last ALU beat; lane data in the same cycle is still merged
//   vm          (mask build only) 1 = unmasked, latched at start
//   v0_mask     (mask build only) element mask, latched at start
//   wb_ready    register file accepts the write
//   wb_valid    write-back request
//   wb_addr     latched destination register number
//   wb_data     assembled destination register
//   wb_be       byte enables, 1 = byte written
//   busy        collector is not idle
//
// Build option
//   RVV_COLLECT_MASK_EN  adds vm / v0_mask ports; with vm=0 only elements whose
//                        v0_mask bit is set are merged. Undefined by default.
// ---------------------------------------------------------------------------
module rvv_vd_collector #(
    parameter int unsigned VLEN     = 128,
    parameter int unsigned NB_LANES = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        run,
    input  logic [2:0]                  vsew,
    input  logic [4:0]                  vd_addr_in,
    input  logic [(64<<NB_LANES)-1:0]   lane_vd,
    input  logic [(10<<NB_LANES)-1:0]   lane_idx,
    input  logic [(1<<NB_LANES)-1:0]    lane_valid,
    input  logic                        alu_done,
`ifdef RVV_COLLECT_MASK_EN
    input  logic                        vm,
    input  logic [VLEN-1:0]             v0_mask,
`endif
    input  logic                        wb_ready,
    output logic                        wb_valid,
    output logic [4:0]                  wb_addr,
    output logic [VLEN-1:0]             wb_data,
    output logic [VLEN/8-1:0]           wb_be,
    output logic                        busy
);

    localparam int unsigned NLANES = 1 << NB_LANES;
    localparam int unsigned NBYTES = VLEN / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic                run_q;
    logic [1:0]          sew_q;
    logic [VLEN-1:0]     buf_data;
    logic [NBYTES-1:0]   buf_be;
    logic [4:0]          addr_q;

    logic                start;
    logic                cmd_ok;
    logic [1:0]          sew_eff;
    logic [VLEN-1:0]     merged_data;
    logic [NBYTES-1:0]   merged_be;

`ifdef RVV_COLLECT_MASK_EN
    logic                vm_q;
    logic [VLEN-1:0]     mask_q;
    logic                vm_eff;
    logic [VLEN-1:0]     mask_eff;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        wb_valid  = 1'b0;
        busy      = (state != IDLE);

        case (state)
            IDLE: begin
                if (start && cmd_ok) begin
                    // a one-beat command can finish in its own start cycle
                    state_nxt = alu_done ? WRITE : COLLECT;
                end
            end
            COLLECT: begin
                if (alu_done) begin
                    state_nxt = WRITE;
                end else if (!run) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Lane merge
    //
    // Works byte by byte: byte b belongs to element b >> sew and is byte
    // (b mod element-size) of that element. Because VLEN is a multiple of
    // 64, any element index that maps onto a byte of the buffer lies fully
    // inside it, so an index past the end simply never matches and the
    // lane is dropped. Lanes are scanned in ascending order so the
    // higher-numbered lane wins on a conflict.
    // ------------------------------------------------------------------
    always_comb begin
        start   = run & ~run_q;
        cmd_ok  = (vsew <= 3'd3);
        sew_eff = (state == IDLE) ? vsew[1:0] : sew_q;

`ifdef RVV_COLLECT_MASK_EN
        vm_eff   = (state == IDLE) ? vm      : vm_q;
        mask_eff = (state == IDLE) ? v0_mask : mask_q;
`endif

        // a new command starts from an empty buffer
        if (state == IDLE) begin
            merged_data = '0;
            merged_be   = '0;
        end else begin
            merged_data = buf_data;
            merged_be   = buf_be;
        end

        for (int b = 0; b < int'(NBYTES); b++) begin
            for (int k = 0; k < int'(NLANES); k++) begin
                if (lane_valid[k]
                    && (int'(lane_idx[10*k +: 10]) == (b >> sew_eff))
`ifdef RVV_COLLECT_MASK_EN
                    && (vm_eff || mask_eff[b >> sew_eff])
`endif
                   ) begin
                    merged_data[8*b +: 8] =
                        lane_vd[64*k + 8*(b & ((1 << sew_eff) - 1)) +: 8];
                    merged_be[b] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_q    <= 1'b0;
            sew_q    <= 2'd0;
            buf_data <= '0;
            buf_be   <= '0;
            addr_q   <= 5'd0;
`ifdef RVV_COLLECT_MASK_EN
            vm_q     <= 1'b1;
            mask_q   <= '0;
`endif
        end else begin
            run_q <= run;

            case (state)
                IDLE: begin
                    if (start && cmd_ok) begin
                        buf_data <= merged_data;
                        buf_be   <= merged_be;
                        addr_q   <= vd_addr_in;
                        sew_q    <= vsew[1:0];
`ifdef RVV_COLLECT_MASK_EN
                        vm_q     <= vm;
                        mask_q   <= v0_mask;
`endif
                    end
                end
                COLLECT: begin
                    if (alu_done || run) begin
                        buf_data <= merged_data;
                        buf_be   <= merged_be;
                    end else begin
                        // abort: drop everything collected so far
                        buf_data <= '0;
                        buf_be   <= '0;
                    end
                end
                default: begin
                    // WRITE holds the buffer stable until the handshake
                end
            endcase
        end
    end

    assign wb_addr = addr_q;
    assign wb_data = buf_data;
    assign wb_be   = buf_be;

endmodule

// File: tb/tb_rvv_vd_collector.sv
// ---------------------------------------------------------------------------
// tb_rvv_vd_collector
//
// Self-checking bench for rvv_vd_collector (VLEN=128, two lanes). Each
// command is mirrored in a small element-level model; when alu_done is
// driven the expected write-back is queued, and every handshake seen on
// the write-back port is popped and compared. Define RVV_COLLECT_MASK_EN to
// also exercise the masked build.
// ---------------------------------------------------------------------------
module tb_rvv_vd_collector;

    localparam int VLEN     = 128;
    localparam int NB_LANES = 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          run;
    logic [2:0]    vsew;
    logic [4:0]    vd_addr_in;
    logic [127:0]  lane_vd;
    logic [19:0]   lane_idx;
    logic [1:0]    lane_valid;
    logic          alu_done;
    logic          wb_ready;
    logic          wb_valid;
    logic [4:0]    wb_addr;
    logic [127:0]  wb_data;
    logic [15:0]   wb_be;
    logic          busy;
`ifdef RVV_COLLECT_MASK_EN
    logic          vm;
    logic [127:0]  v0_mask;
`endif

    rvv_vd_collector #(
        .VLEN     (VLEN),
        .NB_LANES (NB_LANES)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .run        (run),
        .vsew       (vsew),
        .vd_addr_in (vd_addr_in),
        .lane_vd    (lane_vd),
        .lane_idx   (lane_idx),
        .lane_valid (lane_valid),
        .alu_done   (alu_done),
`ifdef RVV_COLLECT_MASK_EN
        .vm         (vm),
        .v0_mask    (v0_mask),
`endif
        .wb_ready   (wb_ready),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_be      (wb_be),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    int hs0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [4:0]   addr;
        logic [127:0] data;
        logic [15:0]  be;
    } wb_t;

    wb_t           sb_q[$];
    wb_t           sb_item;

    logic [127:0]  m_data;
    logic [15:0]   m_be;
    logic [1:0]    m_sew;
    logic [4:0]    m_addr;
    logic          m_vm = 1'b1;
    logic [127:0]  m_mask = '0;
    logic          m_expect_wb = 1'b1;

    task automatic model_lane(input logic [9:0] e, input logic [63:0] d);
        int nb;
        int ei;
        nb = 1 << m_sew;
        ei = int'(e);
        if ((ei + 1) * nb * 8 > VLEN) return;
        if (!m_vm && !m_mask[ei]) return;
        for (int j = 0; j < nb; j++) begin
            m_data[(ei*nb + j)*8 +: 8] = d[j*8 +: 8];
            m_be[ei*nb + j]            = 1'b1;
        end
    endtask

    // write-back monitor, sampled half a cycle before the accepting edge
    always @(negedge clk) begin
        if (resetn && wb_valid && wb_ready) begin
            n_hs++;
            if (sb_q.size() == 0) begin
                check("unexpected_wb", 1'b1, 1'b0);
            end else begin
                sb_item = sb_q.pop_front();
                check("sb_addr", wb_addr, sb_item.addr);
                check("sb_data", wb_data, sb_item.data);
                check("sb_be",   wb_be,   sb_item.be);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        run        = 1'b0;
        lane_valid = 2'b00;
        alu_done   = 1'b0;
        step();
    endtask

    task automatic start_cmd(input logic [2:0] sew, input logic [4:0] addr);
        vsew       = sew;
        vd_addr_in = addr;
        m_sew      = sew[1:0];
        m_addr     = addr;
        m_data     = '0;
        m_be       = '0;
    endtask

    task automatic beat(input logic [1:0] v,
                        input logic [9:0] i0, input logic [63:0] d0,
                        input logic [9:0] i1, input logic [63:0] d1,
                        input logic done);
        run        = 1'b1;
        lane_valid = v;
        lane_idx   = {i1, i0};
        lane_vd    = {d1, d0};
        alu_done   = done;
        if (v[0]) model_lane(i0, d0);
        if (v[1]) model_lane(i1, d1);
        if (done && m_expect_wb) sb_q.push_back('{addr: m_addr, data: m_data, be: m_be});
        step();
    endtask

    // 8 beats, two SEW8 lanes each, element e carries e+1; later beats
    // change vsew / vd_addr_in, which the collector must ignore
    task automatic full_fill(input logic [4:0] addr);
        start_cmd(3'd0, addr);
        for (int c = 0; c < 8; c++) begin
            beat(2'b11, 10'(2*c), 64'(2*c + 1), 10'(2*c + 1), 64'(2*c + 2), c == 7);
            if (c == 0) begin
                vsew       = 3'd3;
                vd_addr_in = 5'd31;
            end
        end
        run        = 1'b0;
        lane_valid = 2'b00;
        alu_done   = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        resetn     = 1'b0;
        run        = 1'b0;
        vsew       = 3'd0;
        vd_addr_in = 5'd0;
        lane_vd    = '0;
        lane_idx   = '0;
        lane_valid = '0;
        alu_done   = 1'b0;
        wb_ready   = 1'b1;
`ifdef RVV_COLLECT_MASK_EN
        vm         = 1'b1;
        v0_mask    = '0;
`endif
        repeat (3) step();
        check("rst_valid", wb_valid, 1'b0);
        check("rst_busy",  busy,     1'b0);
        check("rst_addr",  wb_addr,  5'd0);
        check("rst_data",  wb_data,  128'd0);
        check("rst_be",    wb_be,    16'd0);
        resetn = 1'b1;
        step();

        // 1: full SEW8 fill
        hs0 = n_hs;
        full_fill(5'd5);
        check("t1_valid", wb_valid, 1'b1);
        check("t1_busy",  busy,     1'b1);
        check("t1_addr",  wb_addr,  5'd5);
        check("t1_data",  wb_data,  128'h100F0E0D0C0B0A090807060504030201);
        check("t1_be",    wb_be,    16'hFFFF);
        step();
        check("t1_hs",     n_hs,     hs0 + 1);
        check("t1_valid0", wb_valid, 1'b0);
        check("t1_idle",   busy,     1'b0);

        // 2: backpressure
        idle();
        wb_ready = 1'b0;
        hs0 = n_hs;
        full_fill(5'd9);
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_valid", wb_valid, 1'b1);
            check("t2_hold_data",  wb_data,  128'h100F0E0D0C0B0A090807060504030201);
            step();
        end
        check("t2_valid4", wb_valid, 1'b1);
        check("t2_addr",   wb_addr,  5'd9);
        check("t2_nohs",   n_hs,     hs0);
        wb_ready = 1'b1;
        step();
        check("t2_hs",     n_hs,     hs0 + 1);
        check("t2_valid0", wb_valid, 1'b0);
        check("t2_idle",   busy,     1'b0);

        // 3: SEW32 partial plus out-of-range lane, done in start cycle
        idle();
        start_cmd(3'd2, 5'd3);
        beat(2'b11, 10'd1, 64'hFFFF_FFFF_DEAD_BEEF, 10'd4, 64'hABCD_0000_1234_5678, 1'b1);
        run = 1'b0; lane_valid = 2'b00; alu_done = 1'b0;
        check("t3_valid", wb_valid, 1'b1);
        check("t3_data",  wb_data,  128'h00000000_00000000_DEADBEEF_00000000);
        check("t3_be",    wb_be,    16'h00F0);
        step();
        check("t3_idle",  busy,     1'b0);

        // 4a: abort after 3 beats
        idle();
        hs0 = n_hs;
        start_cmd(3'd0, 5'd7);
        for (int c = 0; c < 3; c++) beat(2'b11, 10'(2*c), 64'h55, 10'(2*c + 1), 64'h66, 1'b0);
        idle();
        check("t4a_busy", busy,  1'b0);
        check("t4a_be",   wb_be, 16'd0);
        repeat (3) begin
            check("t4a_valid", wb_valid, 1'b0);
            step();
        end
        check("t4a_nohs", n_hs, hs0);

        // 4b: reset while waiting in WRITE
        wb_ready    = 1'b0;
        m_expect_wb = 1'b0;
        hs0 = n_hs;
        start_cmd(3'd1, 5'd2);
        beat(2'b01, 10'd0, 64'h1234, 10'd0, 64'd0, 1'b1);
        check("t4b_valid", wb_valid, 1'b1);
        resetn = 1'b0; run = 1'b0; lane_valid = 2'b00; alu_done = 1'b0;
        step();
        check("t4b_valid0", wb_valid, 1'b0);
        check("t4b_busy",   busy,     1'b0);
        check("t4b_be",     wb_be,    16'd0);
        check("t4b_addr",   wb_addr,  5'd0);
        resetn   = 1'b1;
        wb_ready = 1'b1;
        step();
        check("t4b_valid1", wb_valid, 1'b0);
        check("t4b_nohs",   n_hs,     hs0);
        m_expect_wb = 1'b1;

        // 5: lane conflict, higher lane wins
        idle();
        start_cmd(3'd3, 5'd11);
        beat(2'b11, 10'd0, 64'hAA, 10'd0, 64'hBB, 1'b1);
        run = 1'b0; lane_valid = 2'b00; alu_done = 1'b0;
        check("t5_data", wb_data, 128'hBB);
        check("t5_be",   wb_be,   16'h00FF);
        step();

        // later beat overwrites earlier data (SEW16, element 2)
        idle();
        start_cmd(3'd1, 5'd12);
        beat(2'b01, 10'd2, 64'h1111, 10'd0, 64'd0, 1'b0);
        beat(2'b10, 10'd0, 64'd0, 10'd2, 64'h2222, 1'b1);
        run = 1'b0; lane_valid = 2'b00; alu_done = 1'b0;
        check("t7_data", wb_data, 128'h2222_0000_0000);
        check("t7_be",   wb_be,   16'h0030);
        step();

        // illegal vsew is ignored
        idle();
        m_expect_wb = 1'b0;
        start_cmd(3'd4, 5'd13);
        beat(2'b11, 10'd0, 64'h77, 10'd1, 64'h88, 1'b1);
        check("t8_busy",  busy,     1'b0);
        check("t8_valid", wb_valid, 1'b0);
        idle();
        m_expect_wb = 1'b1;

`ifdef RVV_COLLECT_MASK_EN
        // 6: masked fill
        idle();
        vm      = 1'b0;
        v0_mask = 128'h5555;
        m_vm    = 1'b0;
        m_mask  = 128'h5555;
        full_fill(5'd6);
        check("t6_be",   wb_be,   16'h5555);
        check("t6_data", wb_data, 128'h000F000D000B00090007000500030001);
        step();
        vm      = 1'b1;
        m_vm    = 1'b1;
`endif

        idle();
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
